// File: rtl/axis_flit_egress_buffer_if.sv
// AXI4-Stream bundle used by the flit egress buffer.
// Master drives payload and tvalid; slave drives tready.
interface axi_stream_interface #(
  parameter int DATA_W = 64,
  parameter int ID_W   = 8,
  parameter int DEST_W = 4,
  parameter int USER_W = 8
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tstrb;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic [ID_W-1:0]     tid;
  logic [DEST_W-1:0]   tdest;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tstrb, tkeep, tlast,
    output tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast,
    input  tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_flit_egress_buffer.sv
// OutPortSimple flit -> AXI4-Stream FIFO bridge with stats.
// Define AXIS_STORE_FORWARD_EN to hold packets until a tail is buffered.
`ifndef DEST_BITS
`define DEST_BITS 4
`endif
`ifndef VC_BITS
`define VC_BITS 2
`endif

module axis_flit_egress_buffer #(
  parameter int DATA_W    = 64,
  parameter int ID_W      = 8,
  parameter int DEST_W    = 4,
  parameter int USER_W    = 8,
  parameter int DEST_BITS = `DEST_BITS,
  parameter int VC_BITS   = `VC_BITS,
  parameter int DEPTH     = 4,
  parameter int STRB_W    = DATA_W / 8,
  parameter int FLIT_DATA_W =
    USER_W + DEST_W + ID_W + 1 + 2 * STRB_W + DATA_W,
  parameter int FLIT_W =
    FLIT_DATA_W + 2 + DEST_BITS + VC_BITS,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLIT_W-1:0] get_flit,
  input  logic              get_flit_valid,
  output logic              get_flit_ready,
  axi_stream_interface.master axis,
  output logic [OCC_W-1:0]  occupancy,
  output logic [15:0]       pkt_count,
  output logic              tail_err
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LAST_B = DATA_W + 2 * STRB_W;
  localparam int ID_B   = LAST_B + 1;
  localparam int DEST_B = ID_B + ID_W;
  localparam int USER_B = DEST_B + DEST_W;

  logic [FLIT_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [15:0]      pkt_q, pkt_d;
  logic             terr_q, terr_d;

  logic [FLIT_DATA_W-1:0] wdata;
  logic [FLIT_DATA_W-1:0] rdata;
  logic tail_in;
  logic wr_en;
  logic rd_en;
  logic tvalid;
  logic unused_flit_bits;

  assign wdata   = get_flit[FLIT_DATA_W-1:0];
  assign tail_in = get_flit[FLIT_W-2];
  assign unused_flit_bits = ^{get_flit[FLIT_W-1],
    get_flit[FLIT_W-3:FLIT_DATA_W]};

  assign get_flit_ready = (occ_q < OCC_W'(DEPTH));
  assign wr_en = get_flit_valid && get_flit_ready;
  assign rd_en = tvalid && axis.tready;
  assign rdata = mem_q[rd_ptr_q];

`ifdef AXIS_STORE_FORWARD_EN
  logic [OCC_W-1:0] tails_q, tails_d;
  logic tail_wr;
  logic last_rd;

  assign tail_wr = wr_en && tail_in;
  assign last_rd = rd_en && rdata[LAST_B];
  // Full with no tail: release cut-through or nothing ever drains.
  assign tvalid = (occ_q != '0) &&
    (tails_q != '0 || occ_q == OCC_W'(DEPTH));

  always_comb begin
    tails_d = tails_q;
    unique case ({tail_wr, last_rd})
      2'b10:   tails_d = tails_q + OCC_W'(1);
      2'b01:   tails_d = tails_q - OCC_W'(1);
      default: tails_d = tails_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) tails_q <= '0;
    else     tails_q <= tails_d;
  end
`else
  assign tvalid = (occ_q != '0);
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    terr_d   = terr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (tail_in != wdata[LAST_B]) terr_d = 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (rdata[LAST_B]) pkt_d = pkt_q + 16'd1;
    end
    unique case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      terr_q   <= terr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign axis.tvalid = tvalid;
  assign axis.tdata  = rdata[DATA_W-1:0];
  assign axis.tstrb  = rdata[DATA_W+:STRB_W];
  assign axis.tkeep  = rdata[DATA_W+STRB_W+:STRB_W];
  assign axis.tlast  = rdata[LAST_B];
  assign axis.tid    = rdata[ID_B+:ID_W];
  assign axis.tdest  = rdata[DEST_B+:DEST_W];
  assign axis.tuser  = rdata[USER_B+:USER_W];

  assign occupancy = occ_q;
  assign pkt_count = pkt_q;
  assign tail_err  = terr_q;
endmodule

// File: tb/tb_axis_flit_egress_buffer.sv
// Directed bench for axis_flit_egress_buffer at default params.
// Store-and-forward cases build with AXIS_STORE_FORWARD_EN.
`ifndef DEST_BITS
`define DEST_BITS 4
`endif
`ifndef VC_BITS
`define VC_BITS 2
`endif

module tb_axis_flit_egress_buffer;
  localparam int DB = `DEST_BITS;
  localparam int VB = `VC_BITS;
  localparam int FDW = 101;
  localparam int FW = FDW + 2 + DB + VB;

  logic clk = 1'b0;
  logic rst;
  logic [FW-1:0] flit;
  logic flit_vld;
  logic flit_rdy;
  logic [2:0] occ;
  logic [15:0] pkts;
  logic terr;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int first_fire = -1;
  int last_fire = -1;
  int max_occ = 0;
  logic [63:0] rxq[$];

  axi_stream_interface #(64, 8, 4, 8) axis_if ();

  axis_flit_egress_buffer dut (
    .CLK(clk), .RST(rst),
    .get_flit(flit), .get_flit_valid(flit_vld),
    .get_flit_ready(flit_rdy), .axis(axis_if),
    .occupancy(occ), .pkt_count(pkts),
    .tail_err(terr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (int'(occ) > max_occ) max_occ <= int'(occ);
    if (axis_if.tvalid && axis_if.tready) begin
      rxq.push_back(axis_if.tdata);
      if (first_fire < 0) first_fire <= cyc;
      last_fire <= cyc;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(
    input logic [63:0] d, input logic [7:0] keep,
    input logic lst, input logic [7:0] id,
    input logic [3:0] dst, input logic [7:0] usr,
    input logic tail);
    logic [FDW-1:0] data;
    data = {usr, dst, id, lst, keep, keep, d};
    return {1'b1, tail, {DB{1'b0}}, {VB{1'b0}}, data};
  endfunction

  function automatic logic [FW-1:0] beat(
    input logic [63:0] d, input logic lst);
    return mk(d, 8'hFF, lst, 8'h01, 4'h2, 8'h00, lst);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    #1;
    rxq.delete();
    first_fire = -1;
    last_fire = -1;
    max_occ = 0;
    #3;
  endtask

  task automatic drain();
    int n = 0;
    flit_vld = 1'b0;
    axis_if.tready = 1'b1;
    while (occ != 0 && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("drain_timeout", 1, 0);
    step();
  endtask

  task automatic push_n(input logic [63:0] base,
                        input int n, input int last_at);
    int k = 0;
    int bound = 0;
    while (k < n && bound < 60) begin
      flit_vld = 1'b1;
      flit = beat(base + 64'(k), k == last_at);
      if (flit_rdy) begin
        step();
        k++;
      end else step();
      bound++;
    end
    if (bound >= 60) chk("push_timeout", 1, 0);
    flit_vld = 1'b0;
  endtask

  task automatic chk_rx(input string tag,
                        input logic [63:0] base,
                        input int n);
    chk({tag, "_cnt"}, 64'(rxq.size()), 64'(n));
    for (int i = 0; i < n; i++)
      if (i < rxq.size())
        chk({tag, "_dat"}, rxq[i], base + 64'(i));
  endtask

  initial begin
    int acc;
    rst = 1'b1;
    flit = '0;
    flit_vld = 1'b0;
    axis_if.tready = 1'b0;
    step();
    step();
    chk("rst_tvalid", 64'(axis_if.tvalid), 0);
    chk("rst_ready", 64'(flit_rdy), 1);
    chk("rst_occ", 64'(occ), 0);
    chk("rst_pkt", 64'(pkts), 0);
    chk("rst_terr", 64'(terr), 0);
    rst = 1'b0;
    step();

    // single tail beat
    axis_if.tready = 1'b1;
    flit = mk(64'h1122334455667788, 8'hFF, 1'b1,
              8'h05, 4'h3, 8'hA5, 1'b1);
    flit_vld = 1'b1;
    step();
    flit_vld = 1'b0;
    chk("sb_tvalid", 64'(axis_if.tvalid), 1);
    chk("sb_tdata", axis_if.tdata, 64'h1122334455667788);
    chk("sb_tkeep", 64'(axis_if.tkeep), 64'hFF);
    chk("sb_tstrb", 64'(axis_if.tstrb), 64'hFF);
    chk("sb_tlast", 64'(axis_if.tlast), 1);
    chk("sb_tid", 64'(axis_if.tid), 64'h05);
    chk("sb_tdest", 64'(axis_if.tdest), 64'h3);
    chk("sb_tuser", 64'(axis_if.tuser), 64'hA5);
    chk("sb_occ", 64'(occ), 1);
    step();
    chk("sb_pkt", 64'(pkts), 1);
    chk("sb_terr", 64'(terr), 0);
    chk("sb_empty", 64'(axis_if.tvalid), 0);

`ifndef AXIS_STORE_FORWARD_EN
    // 16-beat back-to-back packet
    clear_mon();
    axis_if.tready = 1'b1;
    push_n(64'h1000, 16, 15);
    drain();
    chk_rx("tp", 64'h1000, 16);
    chk("tp_span", 64'(last_fire - first_fire), 15);
    chk("tp_maxocc", 64'(max_occ <= 1), 1);
    chk("tp_pkt", 64'(pkts), 2);

    // backpressure until full
    clear_mon();
    axis_if.tready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      flit_vld = 1'b1;
      flit = beat(64'h100 + 64'(acc), acc == 5);
      if (flit_rdy) acc++;
      step();
    end
    chk("bp_acc", 64'(acc), 4);
    chk("bp_ready", 64'(flit_rdy), 0);
    chk("bp_occ", 64'(occ), 4);
    chk("bp_tvalid", 64'(axis_if.tvalid), 1);
    axis_if.tready = 1'b1;
    step();
    chk("bp_rd_only_occ", 64'(occ), 3);
    chk("bp_ready_back", 64'(flit_rdy), 1);
    while (acc < 6) begin
      flit = beat(64'h100 + 64'(acc), acc == 5);
      if (flit_rdy) acc++;
      step();
    end
    drain();
    chk_rx("bp", 64'h100, 6);
    chk("bp_pkt", 64'(pkts), 3);

    // simultaneous read/write at occupancy 2
    axis_if.tready = 1'b0;
    push_n(64'h300, 2, -1);
    chk("rw_occ_pre", 64'(occ), 2);
    axis_if.tready = 1'b1;
    flit = beat(64'h302, 1'b0);
    flit_vld = 1'b1;
    step();
    flit_vld = 1'b0;
    chk("rw_occ", 64'(occ), 2);
    drain();
    chk("rw_terr", 64'(terr), 0);

    // tail set but tlast field clear
    flit = mk(64'h400, 8'hFF, 1'b0, 8'h01, 4'h2,
              8'h00, 1'b1);
    flit_vld = 1'b1;
    step();
    flit_vld = 1'b0;
    chk("te_set", 64'(terr), 1);
    drain();
    step();
    chk("te_sticky", 64'(terr), 1);
    chk("te_pkt", 64'(pkts), 3);
`else
    // tail arrives after a gap: no release before it
    clear_mon();
    axis_if.tready = 1'b1;
    push_n(64'h500, 2, -1);
    chk("sf_gap0", 64'(axis_if.tvalid), 0);
    step();
    chk("sf_gap1", 64'(axis_if.tvalid), 0);
    step();
    chk("sf_gap2", 64'(axis_if.tvalid), 0);
    chk("sf_gap_occ", 64'(occ), 2);
    flit = beat(64'h502, 1'b1);
    flit_vld = 1'b1;
    step();
    flit_vld = 1'b0;
    chk("sf_tail_tv", 64'(axis_if.tvalid), 1);
    drain();
    chk_rx("sf3", 64'h500, 3);

    // longer than depth: escape at full
    clear_mon();
    axis_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flit = beat(64'h600 + 64'(i), 1'b0);
      flit_vld = 1'b1;
      chk("sf_hold", 64'(axis_if.tvalid), 0);
      step();
    end
    chk("sf_full_occ", 64'(occ), 4);
    chk("sf_escape", 64'(axis_if.tvalid), 1);
    push_n(64'h604, 2, 1);
    drain();
    chk_rx("sf6", 64'h600, 6);
`endif

    // reset with a partial packet buffered
    clear_mon();
    axis_if.tready = 1'b0;
    push_n(64'h700, 3, -1);
    chk("mr_occ_pre", 64'(occ), 3);
    rst = 1'b1;
    step();
    chk("mr_tvalid", 64'(axis_if.tvalid), 0);
    chk("mr_occ", 64'(occ), 0);
    chk("mr_pkt", 64'(pkts), 0);
    chk("mr_ready", 64'(flit_rdy), 1);
    chk("mr_terr", 64'(terr), 0);
    rst = 1'b0;
    step();
    clear_mon();
    axis_if.tready = 1'b1;
    push_n(64'h800, 2, 1);
    drain();
    chk_rx("mr_new", 64'h800, 2);
    chk("mr_new_pkt", 64'(pkts), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
